gpio_bus_arbiter: RTL and testbench
===================================

// Module: gpio_bus_arbiter
// PURPOSE
//  Shares the single GPIO peripheral register port (write/addr/wdata/rdata)
//  between two requesters: m0 (CPU load/store unit) and m1 (debug/DMA agent).
//  Arbitrates, then issues exactly one bus access per grant and returns
//  registered read data with a response pulse.
//  Sits between the requesters and the GPIO instance; the GPIO sees a single master.
// PARAMETERS
//  ADDR_W     3   GPIO register address width
//  DATA_W     32  data width of wdata/rdata
//  PRIO_MODE  0   0 = round-robin; 1 = fixed priority, m0 always wins ties
// PORTS
//  clk_i        in   1       system clock, all state on rising edge
//  rst_i        in   1       asynchronous reset, active-high
//  m0_req_i     in   1       m0 request; held with command until m0_gnt_o
//  m0_we_i      in   1       m0 write enable (1 = write, 0 = read)
//  m0_addr_i    in   ADDR_W  m0 register address
//  m0_wdata_i   in   DATA_W  m0 write data
//  m0_gnt_o     out  1       one-cycle pulse: m0 command latched
//  m0_rvalid_o  out  1       one-cycle pulse: m0 access done, m0_rdata_o valid
//  m0_rdata_o   out  DATA_W  m0 read data (0 for writes)
//  m1_*         same set as m0_* for requester m1
//  write_o      out  1       to GPIO write_i
//  addr_o       out  ADDR_W  to GPIO addr_i
//  wdata_o      out  DATA_W  to GPIO wdata_i
//  rdata_i      in   DATA_W  from GPIO rdata_o (combinational on addr_o)
// BEHAVIOUR
//  Reset (async, any time, incl. mid-access): state=IDLE, all outputs 0,
//   latched command cleared, RR pointer last=m1 (so m0 wins first tie).
//   An access interrupted by reset produces no gnt/rvalid afterwards.
//  FSM states: IDLE -> ISSUE -> RESP -> IDLE.
//  IDLE: if no req, stay. Else pick winner W:
//   only one req -> that one; both -> PRIO_MODE=1: m0;
//   PRIO_MODE=0: the one NOT granted last. Latch W, we, addr, wdata;
//   update last=W; registered gnt_o[W]=1 next cycle; go ISSUE.
//  ISSUE (1 cycle, gnt pulse visible): write_o=latched we, addr_o/wdata_o=
//   latched values; rdata_i sampled at end of cycle; go RESP.
//  RESP (1 cycle): rvalid_o[W]=1, rdata_o[W]=sampled rdata (0 if write);
//   go IDLE. Requests seen in this cycle are arbitrated next (IDLE) cycle.
//  Outside ISSUE: write_o=0, addr_o=0, wdata_o=0 (bus idle, no stray writes).
//  Latency: req seen in cycle N -> gnt in N+1, bus access N+1, rvalid N+2.
//   Max throughput one access per 3 cycles.
//  Requester rules: hold req+command stable until gnt; after gnt it may drop
//   req or present a new command; arbiter ignores req in ISSUE/RESP.
//   req dropped before gnt = request withdrawn, no access issued.
//  rdata_o[x] holds its last value until that requester's next rvalid;
//   the loser's rdata_o is never disturbed.
//  gnt and rvalid are never asserted for both requesters in the same cycle.
//  Round-robin guarantee: with both req held continuously, grants alternate
//   m0,m1,m0,... ; no requester waits more than one access of the other.
//  Address/data pass through unmodified; width truncation is the GPIO's concern.
// TESTING
//  1 m0 read addr=0, GPIO input=16'hA5C3 -> gnt N+1, write_o=0 addr_o=0,
//    m0_rvalid N+2, m0_rdata=32'h0000A5C3; m1 outputs unchanged.
//  2 m1 write addr=4 wdata=32'h0000_00FF -> write_o=1 exactly one cycle,
//    GPIO output low byte=8'hFF next cycle, m1_rvalid with m1_rdata=0.
//  3 both req every cycle, PRIO_MODE=0, 6 accesses -> grant order
//    m0,m1,m0,m1,m0,m1; PRIO_MODE=1 -> m0 six times, m1 starved.
//  4 assert rst_i during ISSUE of a write -> write_o drops to 0 asynchronously,
//    no rvalid after release, next tie granted to m0.
//  5 m0 req dropped before gnt while m1 busy -> no m0 gnt/access/rvalid.
//  6 back-to-back m0 reads addr 0 then 4 with no idle -> rvalid every 3 cycles,
//    data matches IDR then ODR; write_o never asserted.

Source files
------------

// File: rtl/gpio_bus_arbiter_if.sv
// Requester-side command/response bundle for one port of gpio_bus_arbiter.
// The requester drives through master; the arbiter answers through slave.
interface gpio_bus_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Two-requester arbiter in front of the single GPIO register port.
// Each grant issues exactly one bus access and returns registered read data.
module gpio_bus_arbiter #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  gpio_bus_arbiter_if.slave   m0,
  gpio_bus_arbiter_if.slave   m1,
  output logic                write_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  input  logic [DATA_W-1:0]   rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              winner;
  logic [DATA_W-1:0] resp_data;

  // A tie goes to m0 in fixed mode, otherwise to whoever was not served last.
  always_comb begin
    if (m0.req && m1.req) begin
      winner = (PRIO_MODE == 1) ? 1'b0 : ~last_q;
    end else begin
      winner = m1.req;
    end
  end

  assign resp_data = we_q ? '0 : rdata_i;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (m0.req || m1.req) begin
          owner_d = winner;
          last_d  = winner;
          we_d    = winner ? m1.we    : m0.we;
          addr_d  = winner ? m1.addr  : m0.addr;
          wdata_d = winner ? m1.wdata : m0.wdata;
          gnt_d   = winner ? 2'b10 : 2'b01;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Only the owner's read-data register moves; the other keeps its value.
        rvalid_d = owner_q ? 2'b10 : 2'b01;
        if (owner_q) begin
          rdata1_d = resp_data;
        end else begin
          rdata0_d = resp_data;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Bus is driven only in ISSUE so a reset mid-access drops write_o at once.
  assign write_o = (state_q == ISSUE) && we_q;
  assign addr_o  = (state_q == ISSUE) ? addr_q  : '0;
  assign wdata_o = (state_q == ISSUE) ? wdata_q : '0;

  assign m0.gnt    = gnt_q[0];
  assign m0.rvalid = rvalid_q[0];
  assign m0.rdata  = rdata0_q;
  assign m1.gnt    = gnt_q[1];
  assign m1.rvalid = rvalid_q[1];
  assign m1.rdata  = rdata1_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_gpio_bus_arbiter;
  localparam int AW = 3;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [1:0]    req = 2'b00;
  logic [1:0]    we  = 2'b00;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata [2];
  logic          write_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [DW-1:0] rdata_i;

  logic [15:0]   gpio_in = 16'h0;
  logic [DW-1:0] gpio_regs [8];

  gpio_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  gpio_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  assign m0_if.req   = req[0];
  assign m0_if.we    = we[0];
  assign m0_if.addr  = addr[0];
  assign m0_if.wdata = wdata[0];
  assign m1_if.req   = req[1];
  assign m1_if.we    = we[1];
  assign m1_if.addr  = addr[1];
  assign m1_if.wdata = wdata[1];
  assign gnt[0]      = m0_if.gnt;
  assign gnt[1]      = m1_if.gnt;
  assign rvalid[0]   = m0_if.rvalid;
  assign rvalid[1]   = m1_if.rvalid;
  assign rdata[0]    = m0_if.rdata;
  assign rdata[1]    = m1_if.rdata;

  gpio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .write_o (write_o),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .rdata_i (rdata_i)
  );

  // GPIO peripheral: addr 0 is the read-only input register, others are storage.
  assign rdata_i = (addr_o == 0) ? {16'h0, gpio_in} : gpio_regs[addr_o];
  always @(posedge clk) begin
    if (write_o && addr_o != 0) gpio_regs[addr_o] <= wdata_o;
  end

  // Fixed-priority instance, both requesters tied to a common request.
  logic          p_req = 1'b0;
  logic          p_write;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [DW-1:0] p_rdata = '0;

  gpio_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
  gpio_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();

  assign p0_if.req   = p_req;
  assign p0_if.we    = 1'b0;
  assign p0_if.addr  = '0;
  assign p0_if.wdata = '0;
  assign p1_if.req   = p_req;
  assign p1_if.we    = 1'b0;
  assign p1_if.addr  = '0;
  assign p1_if.wdata = '0;

  gpio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) dut_prio (
    .clk_i   (clk),
    .rst_i   (rst),
    .m0      (p0_if),
    .m1      (p1_if),
    .write_o (p_write),
    .addr_o  (p_addr),
    .wdata_o (p_wdata),
    .rdata_i (p_rdata)
  );

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: one outstanding access, described by the cycle it was
  // decided in; grant one cycle later, response two cycles later, free after three.
  int            freeAt = 0;
  bit            have   = 1'b0;
  int            decCyc = 0;
  bit            mW, mWe;
  bit            mLast  = 1'b1;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata;
  logic [DW-1:0] mSnap  = '0;
  logic [DW-1:0] mRdata [2];
  logic [DW-1:0] mRegs  [8];

  always @(negedge clk) begin : scoreboard
    logic [1:0]    eGnt, eRv;
    logic          eWrite;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eWdata;
    bit            w;
    if (rst) begin
      have      = 1'b0;
      freeAt    = 0;
      mLast     = 1'b1;
      mRdata[0] = '0;
      mRdata[1] = '0;
    end
    eGnt = 2'b00; eRv = 2'b00; eWrite = 1'b0; eAddr = '0; eWdata = '0;
    if (have && cyc == decCyc + 1) begin
      eGnt[mW] = 1'b1;
      eWrite   = mWe;
      eAddr    = mAddr;
      eWdata   = mWdata;
    end
    if (have && cyc == decCyc + 2) begin
      eRv[mW]    = 1'b1;
      mRdata[mW] = mSnap;
    end
    checkOutput("gnt",      {30'b0, gnt},     {30'b0, eGnt});
    checkOutput("rvalid",   {30'b0, rvalid},  {30'b0, eRv});
    checkOutput("m0_rdata", rdata[0],         mRdata[0]);
    checkOutput("m1_rdata", rdata[1],         mRdata[1]);
    checkOutput("write_o",  {31'b0, write_o}, {31'b0, eWrite});
    checkOutput("addr_o",   {29'b0, addr_o},  {29'b0, eAddr});
    checkOutput("wdata_o",  wdata_o,          eWdata);
    if (have && cyc == decCyc + 1) begin
      if (mWe) begin
        if (mAddr != 0) mRegs[mAddr] = mWdata;
        mSnap = '0;
      end else begin
        mSnap = (mAddr == 0) ? {16'h0, gpio_in} : mRegs[mAddr];
      end
    end
    if (have && cyc == decCyc + 2) have = 1'b0;
    if (!rst && cyc >= freeAt && req != 2'b00) begin
      w      = (req == 2'b11) ? ~mLast : req[1];
      mW     = w;
      mLast  = w;
      mWe    = we[w];
      mAddr  = addr[w];
      mWdata = wdata[w];
      decCyc = cyc;
      freeAt = cyc + 3;
      have   = 1'b1;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic newCmd(input int m);
    req[m]   = 1'b1;
    we[m]    = 1'($urandom_range(1, 0));
    addr[m]  = AW'($urandom);
    wdata[m] = $urandom;
  endtask

  // One cycle of legal random requester behaviour.
  task automatic applyStimulus();
    nextCycle();
    for (int m = 0; m < 2; m++) begin
      if (req[m] && gnt[m]) begin
        if ($urandom_range(1, 0) == 1) newCmd(m);
        else req[m] = 1'b0;
      end else if (req[m]) begin
        if ($urandom_range(15, 0) == 0) req[m] = 1'b0;
      end else if ($urandom_range(2, 0) == 0) begin
        newCmd(m);
      end
    end
    if ($urandom_range(15, 0) == 0) gpio_in = 16'($urandom);
  endtask

  task automatic runAccess(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int gl, output int rl, output logic [DW-1:0] rd,
                           output logic busW, output logic [AW-1:0] busA);
    req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d;
    gl = 0; rl = 0; busW = 1'b0; busA = '0;
    do begin nextCycle(); gl++; end while (!gnt[m] && gl < 20);
    busW   = write_o;
    busA   = addr_o;
    req[m] = 1'b0;
    do begin nextCycle(); rl++; end while (!rvalid[m] && rl < 20);
    rd = rdata[m];
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gl, rl, cnt, cnt2, pm0, pm1, pBad, ng, wr, c;
    logic [DW-1:0] rd;
    logic          busW;
    logic [AW-1:0] busA;
    int            order [$];
    int            rvCyc [$];
    logic [DW-1:0] rvDat [$];

    for (int i = 0; i < 8; i++) begin
      gpio_regs[i] = '0;
      mRegs[i]     = '0;
    end
    for (int m = 0; m < 2; m++) begin
      addr[m] = '0; wdata[m] = '0; mRdata[m] = '0;
    end
    #1 rst = 1'b1;
    repeat (3) nextCycle();
    rst = 1'b0;
    checkOutput("reset_gnt",      {30'b0, gnt}, 0);
    checkOutput("reset_write",    {31'b0, write_o}, 0);
    checkOutput("reset_m0_rdata", rdata[0], 0);
    nextCycle();

    // Single m0 read of the input register.
    gpio_in = 16'hA5C3;
    runAccess(0, 1'b0, 3'd0, 32'h0, gl, rl, rd, busW, busA);
    checkOutput("t1_gnt_latency",    gl, 1);
    checkOutput("t1_rvalid_latency", rl, 1);
    checkOutput("t1_m0_rdata",       rd, 32'h0000A5C3);
    checkOutput("t1_bus_write",      {31'b0, busW}, 0);
    checkOutput("t1_bus_addr",       {29'b0, busA}, 0);
    checkOutput("t1_m1_rdata_kept",  rdata[1], 0);
    nextCycle();

    // Single m1 write to the output register.
    runAccess(1, 1'b1, 3'd4, 32'h0000_00FF, gl, rl, rd, busW, busA);
    checkOutput("t2_gnt_latency",    gl, 1);
    checkOutput("t2_rvalid_latency", rl, 1);
    checkOutput("t2_bus_write",      {31'b0, busW}, 1);
    checkOutput("t2_bus_addr",       {29'b0, busA}, 4);
    checkOutput("t2_m1_rdata",       rd, 0);
    checkOutput("t2_odr_low_byte",   {24'b0, gpio_regs[4][7:0]}, 32'hFF);
    checkOutput("t2_m0_rdata_kept",  rdata[0], 32'h0000A5C3);
    nextCycle();

    // Both requesters held: alternation in RR, starvation of m1 in fixed mode.
    req = 2'b11; we = 2'b00; addr[0] = 3'd4; addr[1] = 3'd4;
    p_req = 1'b1;
    pm0 = 0; pm1 = 0; pBad = 0;
    for (int i = 0; i < 40 && order.size() < 6; i++) begin
      nextCycle();
      if (gnt[0]) order.push_back(0);
      if (gnt[1]) order.push_back(1);
      if (p0_if.gnt) pm0++;
      if (p1_if.gnt) pm1++;
      if (p_write || p_addr != 0 || p_wdata != 0) pBad++;
    end
    req = 2'b00; p_req = 1'b0;
    checkOutput("t3_grant_count", order.size(), 6);
    for (int i = 0; i < order.size(); i++)
      checkOutput($sformatf("t3_grant_%0d", i), order[i], i % 2);
    checkOutput("t3_prio_m0_grants", pm0, 6);
    checkOutput("t3_prio_m1_grants", pm1, 0);
    checkOutput("t3_prio_bus_quiet", pBad, 0);
    repeat (2) nextCycle();

    // Reset lands during the ISSUE cycle of an m0 write.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 3'd4; wdata[0] = 32'hDEAD_BEEF;
    nextCycle();
    checkOutput("t4_gnt_before_reset",   {30'b0, gnt}, 32'h1);
    checkOutput("t4_write_before_reset", {31'b0, write_o}, 1);
    req[0] = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("t4_write_async_drop", {31'b0, write_o}, 0);
    nextCycle();
    rst = 1'b0;
    cnt = 0; cnt2 = 0;
    repeat (4) begin
      nextCycle();
      if (rvalid != 0) cnt++;
      if (gnt != 0) cnt2++;
    end
    checkOutput("t4_no_rvalid_after", cnt, 0);
    checkOutput("t4_no_gnt_after",    cnt2, 0);
    checkOutput("t4_odr_unwritten",   gpio_regs[4], 32'hFF);
    req = 2'b11; we = 2'b00; addr[0] = 3'd0; addr[1] = 3'd0;
    c = 0;
    do begin nextCycle(); c++; end while (gnt == 0 && c < 10);
    checkOutput("t4_tie_after_reset", {30'b0, gnt}, 32'h1);
    req[0] = 1'b0;
    c = 0;
    do begin nextCycle(); c++; end while (!gnt[1] && c < 10);
    req[1] = 1'b0;
    repeat (2) nextCycle();

    // m0 request withdrawn while m1 owns the bus.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 3'd0;
    c = 0;
    do begin nextCycle(); c++; end while (!gnt[1] && c < 10);
    req[1] = 1'b0;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 3'd4; wdata[0] = 32'h1234_5678;
    nextCycle();
    req[0] = 1'b0;
    cnt = 0; cnt2 = 0;
    repeat (6) begin
      nextCycle();
      if (gnt[0]) cnt++;
      if (rvalid[0]) cnt2++;
    end
    checkOutput("t5_m0_gnt",    cnt, 0);
    checkOutput("t5_m0_rvalid", cnt2, 0);
    checkOutput("t5_odr_kept",  gpio_regs[4], 32'hFF);

    // Back-to-back m0 reads: input register then output register.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 3'd0;
    ng = 0; wr = 0;
    for (int i = 1; i <= 20 && rvCyc.size() < 2; i++) begin
      nextCycle();
      if (write_o) wr++;
      if (gnt[0]) begin
        ng++;
        if (ng == 1) addr[0] = 3'd4;
        else req[0] = 1'b0;
      end
      if (rvalid[0]) begin
        rvCyc.push_back(i);
        rvDat.push_back(rdata[0]);
      end
    end
    req[0] = 1'b0;
    checkOutput("t6_rvalid_count", rvCyc.size(), 2);
    if (rvCyc.size() == 2) begin
      checkOutput("t6_rvalid_spacing", rvCyc[1] - rvCyc[0], 3);
      checkOutput("t6_idr_data",       rvDat[0], 32'h0000A5C3);
      checkOutput("t6_odr_data",       rvDat[1], 32'h0000_00FF);
    end
    checkOutput("t6_no_write", wr, 0);
    nextCycle();

    repeat (1500) applyStimulus();
    req = 2'b00;
    repeat (5) nextCycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
